// File: rtl/axil_downsizer_64_32_if.sv
// AXI4-Lite bundle shared by the 64-bit and 32-bit sides of the downsizer.
// The master modport drives requests; the slave modport answers them.
interface axil_downsizer_64_32_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_downsizer_64_32.sv
// 64-bit to 32-bit AXI4-Lite width converter, low word first, one txn in flight.
// AXIL_DS_SKIP_EMPTY_EN: write beats with an all-zero strobe half are skipped.
module axil_downsizer_64_32 #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  axil_downsizer_64_32_if.slave  s,
  axil_downsizer_64_32_if.master m
);
  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, S_BRSP, S_RRSP
  } state_t;

  state_t                r_state;
  logic                  r_beat;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [2:0]            r_prot;
  logic [63:0]           r_data;
  logic [7:0]            r_strb;
  logic [1:0]            r_resp;

  logic w_wr_acc;
  logic w_rd_acc;
  assign w_wr_acc = (r_state == IDLE) && s.awvalid && s.wvalid;
  assign w_rd_acc = (r_state == IDLE) && s.arvalid
                    && !(s.awvalid && s.wvalid);
  assign s.awready = w_wr_acc;
  assign s.wready  = w_wr_acc;
  assign s.arready = w_rd_acc;

  // Beat source: live upstream values on accept, latched copy afterwards.
  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_ar_base;
  logic [63:0]           w_data;
  logic [7:0]            w_strb;
  logic [2:0]            w_prot;
  assign w_base    = w_wr_acc ? {s.awaddr[ADDR_WIDTH-1:3], 3'b000} : r_base;
  assign w_ar_base = {s.araddr[ADDR_WIDTH-1:3], 3'b000};
  assign w_data    = w_wr_acc ? s.wdata  : r_data;
  assign w_strb    = w_wr_acc ? s.wstrb  : r_strb;
  assign w_prot    = w_wr_acc ? s.awprot : r_prot;

  logic w_unused;
  assign w_unused = ^{s.awaddr[2:0], s.araddr[2:0]};

  logic w_lo_en;
  logic w_hi_en;
`ifdef AXIL_DS_SKIP_EMPTY_EN
  assign w_lo_en = |w_strb[3:0];
  assign w_hi_en = |w_strb[7:4];
`else
  assign w_lo_en = 1'b1;
  assign w_hi_en = 1'b1;
`endif

  logic w_wr_issue;
  logic w_nb;
  always_comb begin
    w_wr_issue = 1'b0;
    w_nb       = 1'b0;
    if (w_wr_acc) begin
      w_wr_issue = w_lo_en || w_hi_en;
      w_nb       = !w_lo_en;
    end else if (r_state == WR_RSP && m.bvalid && !r_beat) begin
      w_wr_issue = w_hi_en;
      w_nb       = 1'b1;
    end
  end

  // Numeric max gives DECERR > SLVERR > OKAY.
  logic [1:0] w_bmax;
  logic [1:0] w_rmax;
  assign w_bmax = (m.bresp > r_resp) ? m.bresp : r_resp;
  assign w_rmax = (m.rresp > r_resp) ? m.rresp : r_resp;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_beat    <= 1'b0;
      r_base    <= '0;
      r_prot    <= '0;
      r_data    <= '0;
      r_strb    <= '0;
      r_resp    <= '0;
      m.awaddr  <= '0;
      m.awprot  <= '0;
      m.awvalid <= 1'b0;
      m.wdata   <= '0;
      m.wstrb   <= '0;
      m.wvalid  <= 1'b0;
      m.bready  <= 1'b0;
      m.araddr  <= '0;
      m.arprot  <= '0;
      m.arvalid <= 1'b0;
      m.rready  <= 1'b0;
      s.bresp   <= '0;
      s.bvalid  <= 1'b0;
      s.rdata   <= '0;
      s.rresp   <= '0;
      s.rvalid  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_wr_acc) begin
            r_base <= w_base;
            r_prot <= s.awprot;
            r_data <= s.wdata;
            r_strb <= s.wstrb;
            r_resp <= '0;
            r_beat <= 1'b0;
            if (!w_wr_issue) begin
              s.bvalid <= 1'b1;
              s.bresp  <= '0;
              r_state  <= S_BRSP;
            end
          end else if (w_rd_acc) begin
            r_base    <= w_ar_base;
            r_resp    <= '0;
            r_beat    <= 1'b0;
            m.araddr  <= w_ar_base;
            m.arprot  <= s.arprot;
            m.arvalid <= 1'b1;
            r_state   <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (m.awready) m.awvalid <= 1'b0;
          if (m.wready)  m.wvalid  <= 1'b0;
          if ((!m.awvalid || m.awready) && (!m.wvalid || m.wready)) begin
            m.bready <= 1'b1;
            r_state  <= WR_RSP;
          end
        end
        WR_RSP: begin
          if (m.bvalid) begin
            m.bready <= 1'b0;
            r_resp   <= w_bmax;
            if (!w_wr_issue) begin
              s.bvalid <= 1'b1;
              s.bresp  <= w_bmax;
              r_state  <= S_BRSP;
            end
          end
        end
        RD_REQ: begin
          if (m.arready) begin
            m.arvalid <= 1'b0;
            m.rready  <= 1'b1;
            r_state   <= RD_RSP;
          end
        end
        RD_RSP: begin
          if (m.rvalid) begin
            m.rready <= 1'b0;
            r_resp   <= w_rmax;
            if (!r_beat) begin
              s.rdata[31:0] <= m.rdata;
              m.araddr      <= r_base + ADDR_WIDTH'(4);
              m.arvalid     <= 1'b1;
              r_beat        <= 1'b1;
              r_state       <= RD_REQ;
            end else begin
              s.rdata[63:32] <= m.rdata;
              s.rvalid       <= 1'b1;
              s.rresp        <= w_rmax;
              r_state        <= S_RRSP;
            end
          end
        end
        S_BRSP: begin
          if (s.bready) begin
            s.bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        S_RRSP: begin
          if (s.rready) begin
            s.rvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
      // Launch a write beat; overrides the case-arm state update.
      if (w_wr_issue) begin
        r_beat    <= w_nb;
        m.awaddr  <= w_base + {{(ADDR_WIDTH-3){1'b0}}, w_nb, 2'b00};
        m.awprot  <= w_prot;
        m.awvalid <= 1'b1;
        m.wvalid  <= 1'b1;
        m.wdata   <= w_nb ? w_data[63:32] : w_data[31:0];
        m.wstrb   <= w_nb ? w_strb[7:4] : w_strb[3:0];
        r_state   <= WR_REQ;
      end
    end
  end
endmodule

// File: tb/tb_axil_downsizer_64_32.sv
// Directed bench for axil_downsizer_64_32 with a zero-wait 32-bit slave model.
// Honours AXIL_DS_SKIP_EMPTY_EN when the design is built with it.
module tb_axil_downsizer_64_32;
  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axil_downsizer_64_32_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s_if ();
  axil_downsizer_64_32_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axil_downsizer_64_32 #(.ADDR_WIDTH(32)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s       (s_if.slave),
    .m       (m_if.master)
  );

  int total = 0;
  int passed = 0;
  int fails = 0;

  logic [34:0] aw_a [8];
  logic [35:0] w_d  [8];
  logic [31:0] ar_a [8];
  int aw_n, w_n, b_n, ar_n;
  bit clr = 1'b0;
  bit b_hold = 1'b0;
  logic [1:0]  btab  [8];
  logic [31:0] rdtab [8];
  logic [1:0]  rrtab [8];

  // Downstream slave: always ready, responds the cycle after each request.
  always @(posedge aclk) begin
    if (!aresetn || clr) begin
      aw_n = 0; w_n = 0; b_n = 0; ar_n = 0;
      m_if.bvalid <= 1'b0;
      m_if.rvalid <= 1'b0;
    end else begin
      if (m_if.bvalid && m_if.bready) m_if.bvalid <= 1'b0;
      if (m_if.rvalid && m_if.rready) m_if.rvalid <= 1'b0;
      if (m_if.awvalid && m_if.awready) begin
        aw_a[aw_n & 7] = {m_if.awprot, m_if.awaddr};
        aw_n++;
      end
      if (m_if.wvalid && m_if.wready) begin
        w_d[w_n & 7] = {m_if.wstrb, m_if.wdata};
        w_n++;
      end
      if (!b_hold && aw_n > b_n && w_n > b_n) begin
        m_if.bvalid <= 1'b1;
        m_if.bresp  <= btab[b_n & 7];
        b_n++;
      end
      if (m_if.arvalid && m_if.arready) begin
        ar_a[ar_n & 7] = m_if.araddr;
        m_if.rvalid <= 1'b1;
        m_if.rdata  <= rdtab[ar_n & 7];
        m_if.rresp  <= rrtab[ar_n & 7];
        ar_n++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_log();
    @(negedge aclk);
    clr = 1'b1;
    @(negedge aclk);
    clr = 1'b0;
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] st, output logic [1:0] resp,
                       output int lat);
    @(negedge aclk);
    s_if.awaddr  = a;
    s_if.awprot  = 3'b010;
    s_if.wdata   = d;
    s_if.wstrb   = st;
    s_if.awvalid = 1'b1;
    s_if.wvalid  = 1'b1;
    @(posedge aclk);
    #1;
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    lat = 0;
    while (!s_if.bvalid && lat < 50) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    resp = s_if.bresp;
    @(negedge aclk);
    s_if.bready = 1'b1;
    @(posedge aclk);
    #1;
    s_if.bready = 1'b0;
  endtask

  task automatic do_rd(input logic [31:0] a, output logic [63:0] d,
                       output logic [1:0] resp, output int lat);
    @(negedge aclk);
    s_if.araddr  = a;
    s_if.arprot  = 3'b001;
    s_if.arvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_if.arvalid = 1'b0;
    lat = 0;
    while (!s_if.rvalid && lat < 50) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    d    = s_if.rdata;
    resp = s_if.rresp;
    @(negedge aclk);
    s_if.rready = 1'b1;
    @(posedge aclk);
    #1;
    s_if.rready = 1'b0;
  endtask

  logic [1:0]  resp;
  logic [63:0] rd;
  int lat;

  initial begin
    s_if.awaddr = '0; s_if.awprot = '0; s_if.awvalid = 1'b0;
    s_if.wdata = '0; s_if.wstrb = '0; s_if.wvalid = 1'b0;
    s_if.bready = 1'b0; s_if.araddr = '0; s_if.arprot = '0;
    s_if.arvalid = 1'b0; s_if.rready = 1'b0;
    m_if.awready = 1'b1; m_if.wready = 1'b1; m_if.arready = 1'b1;
    m_if.bresp = '0; m_if.rdata = '0; m_if.rresp = '0;
    for (int i = 0; i < 8; i++) begin
      btab[i] = 2'b00; rdtab[i] = '0; rrtab[i] = 2'b00;
    end

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_valids", 64'({m_if.awvalid, m_if.wvalid, m_if.bready,
        m_if.arvalid, m_if.rready, s_if.bvalid, s_if.rvalid}), 64'd0);
    chk("rst_addr", {m_if.awaddr, m_if.araddr}, 64'd0);
    chk("rst_wdata", 64'({m_if.wdata, m_if.wstrb, m_if.awprot, m_if.arprot}),
        64'd0);
    chk("rst_rdata", s_if.rdata, 64'd0);
    chk("rst_resp", 64'({s_if.bresp, s_if.rresp}), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Full 64-bit write, zero-wait
    clr_log();
    do_wr(32'h4000_0008, 64'h1122_3344_5566_7788, 8'hFF, resp, lat);
    chk("wr1_beats", 64'(aw_n), 64'd2);
    chk("wr1_aw0", 64'(aw_a[0]), 64'({3'b010, 32'h4000_0008}));
    chk("wr1_w0", 64'(w_d[0]), 64'({4'hF, 32'h5566_7788}));
    chk("wr1_aw1", 64'(aw_a[1]), 64'({3'b010, 32'h4000_000C}));
    chk("wr1_w1", 64'(w_d[1]), 64'({4'hF, 32'h1122_3344}));
    chk("wr1_bresp", 64'(resp), 64'd0);
    chk("wr1_lat", 64'(lat), 64'd4);

    // Read merge
    clr_log();
    rdtab[0] = 32'hAAAA_0001; rdtab[1] = 32'hBBBB_0002;
    do_rd(32'h4000_0010, rd, resp, lat);
    chk("rd1_data", rd, 64'hBBBB_0002_AAAA_0001);
    chk("rd1_resp", 64'(resp), 64'd0);
    chk("rd1_lat", 64'(lat), 64'd4);
    chk("rd1_ar0", 64'(ar_a[0]), 64'h4000_0010);
    chk("rd1_ar1", 64'(ar_a[1]), 64'h4000_0014);

    // Error merging on reads: beat 0 error does not cancel beat 1
    clr_log();
    rrtab[0] = 2'b10; rrtab[1] = 2'b00;
    do_rd(32'h4000_0010, rd, resp, lat);
    chk("rd_slverr_resp", 64'(resp), 64'd2);
    chk("rd_slverr_beats", 64'(ar_n), 64'd2);
    clr_log();
    rrtab[1] = 2'b11;
    do_rd(32'h4000_0010, rd, resp, lat);
    chk("rd_decerr_resp", 64'(resp), 64'd3);
    rrtab[0] = 2'b00; rrtab[1] = 2'b00;

    // Write response merging
    clr_log();
    btab[0] = 2'b10; btab[1] = 2'b01;
    do_wr(32'h4000_0018, 64'h0, 8'hFF, resp, lat);
    chk("wr_err_bresp", 64'(resp), 64'd2);

    // Upper-half-only strobes
    clr_log();
    btab[0] = 2'b00; btab[1] = 2'b00;
    do_wr(32'h4000_0020, 64'hCAFE_BABE_DEAD_BEEF, 8'hF0, resp, lat);
`ifdef AXIL_DS_SKIP_EMPTY_EN
    chk("f0_beats", 64'(aw_n), 64'd1);
    chk("f0_aw0", 64'(aw_a[0]), 64'({3'b010, 32'h4000_0024}));
    chk("f0_w0", 64'(w_d[0]), 64'({4'hF, 32'hCAFE_BABE}));
`else
    chk("f0_beats", 64'(aw_n), 64'd2);
    chk("f0_w0", 64'(w_d[0]), 64'({4'h0, 32'hDEAD_BEEF}));
    chk("f0_w1", 64'(w_d[1]), 64'({4'hF, 32'hCAFE_BABE}));
`endif
    chk("f0_bresp", 64'(resp), 64'd0);

    // All-zero strobes; slave errors only visible if beats are issued
    clr_log();
    btab[0] = 2'b10; btab[1] = 2'b01;
    do_wr(32'h4000_0028, 64'h1, 8'h00, resp, lat);
`ifdef AXIL_DS_SKIP_EMPTY_EN
    chk("s00_beats", 64'(aw_n), 64'd0);
    chk("s00_bresp", 64'(resp), 64'd0);
`else
    chk("s00_beats", 64'(aw_n), 64'd2);
    chk("s00_bresp", 64'(resp), 64'd2);
`endif
    btab[0] = 2'b00; btab[1] = 2'b00;

    // Write wins over a simultaneous read; read stalled upstream
    clr_log();
    rdtab[0] = 32'h1234_5678; rdtab[1] = 32'h9ABC_DEF0;
    rrtab[0] = 2'b01; rrtab[1] = 2'b00;
    @(negedge aclk);
    s_if.awaddr = 32'h4000_0030; s_if.wdata = 64'h5; s_if.wstrb = 8'hFF;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
    s_if.araddr = 32'h4000_0105; s_if.arvalid = 1'b1;
    #1;
    chk("conf_awready", 64'(s_if.awready), 64'd1);
    chk("conf_arready", 64'(s_if.arready), 64'd0);
    @(posedge aclk);
    #1;
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    lat = 0;
    while (!s_if.bvalid && lat < 50) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    chk("conf_bvalid", 64'(s_if.bvalid), 64'd1);
    chk("conf_ar_busy", 64'(s_if.arready), 64'd0);
    @(negedge aclk);
    s_if.bready = 1'b1;
    @(posedge aclk);
    #1;
    s_if.bready = 1'b0;
    chk("conf_ar_idle", 64'(s_if.arready), 64'd1);
    @(posedge aclk);
    #1;
    s_if.arvalid = 1'b0;
    lat = 0;
    while (!s_if.rvalid && lat < 50) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    chk("conf_ar0", 64'(ar_a[0]), 64'h4000_0100);
    for (int i = 0; i < 3; i++) begin
      chk("stall_rvalid", 64'(s_if.rvalid), 64'd1);
      chk("stall_rdata", s_if.rdata, 64'h9ABC_DEF0_1234_5678);
      chk("stall_rresp", 64'(s_if.rresp), 64'd1);
      @(posedge aclk);
      #1;
    end
    @(negedge aclk);
    s_if.rready = 1'b1;
    @(posedge aclk);
    #1;
    s_if.rready = 1'b0;
    chk("stall_rdone", 64'(s_if.rvalid), 64'd0);

    // Reset while waiting for beat-0 write response
    clr_log();
    rrtab[0] = 2'b00;
    b_hold = 1'b1;
    @(negedge aclk);
    s_if.awaddr = 32'h4000_0040; s_if.wdata = 64'h77; s_if.wstrb = 8'hFF;
    s_if.awvalid = 1'b1; s_if.wvalid = 1'b1;
    @(posedge aclk);
    #1;
    s_if.awvalid = 1'b0; s_if.wvalid = 1'b0;
    lat = 0;
    while (!m_if.bready && lat < 20) begin
      @(posedge aclk);
      #1;
      lat++;
    end
    chk("mid_bready", 64'(m_if.bready), 64'd1);
    chk("mid_awaddr", 64'(m_if.awaddr), 64'h4000_0040);
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    chk("mid_valids", 64'({m_if.awvalid, m_if.wvalid, m_if.bready,
        m_if.arvalid, m_if.rready, s_if.bvalid, s_if.rvalid}), 64'd0);
    chk("mid_addr", {m_if.awaddr, m_if.araddr}, 64'd0);
    chk("mid_wdata", 64'({m_if.wdata, m_if.wstrb, m_if.awprot, m_if.arprot}),
        64'd0);
    chk("mid_rdata", s_if.rdata, 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    b_hold = 1'b0;
    rdtab[0] = 32'h0000_0C0D; rdtab[1] = 32'h0A0B_0000;
    do_rd(32'h4000_0050, rd, resp, lat);
    chk("post_rdata", rd, 64'h0A0B_0000_0000_0C0D);
    chk("post_rresp", 64'(resp), 64'd0);
    chk("post_lat", 64'(lat), 64'd4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
